upscale: RTL and testbench
==========================

// Module: upscale
// PURPOSE
//  Inverse of the filter output rescaler: widens signed IMG_WIDTH pixels into
//  the NUM_WIDTH MAC/ADD number domain. Sign-extends, scales left by 'shift'
//  and saturates on overflow. Sits on the filter input side, feeding the MAC
//  array. Uses a valid/ready stream with a 2-stage elastic pipeline.
// PARAMETERS
//  NUM_WIDTH  33  width of the number (MAC) domain, signed two's complement
//  IMG_WIDTH  16  width of the image pixel domain, signed; IMG_WIDTH < NUM_WIDTH
// PORTS
//  clk       in   1          clock, all logic on posedge
//  rst_n     in   1          reset, asynchronous assert, active-low
//  shift     in   8          left-shift amount, sampled with each accepted beat
//  up_data   in   IMG_WIDTH  signed pixel
//  up_valid  in   1          up_data/shift valid
//  up_ready  out  1          block can accept a beat this cycle
//  dn_data   out  NUM_WIDTH  signed scaled number
//  dn_sat    out  1          dn_data was clamped; qualified by dn_valid
//  dn_valid  out  1          dn_data/dn_sat valid
//  dn_ready  in   1          downstream accepts the beat
// BEHAVIOUR
//  - Reset (rst_n low, async): s1_valid, s2_valid, dn_valid, dn_sat,
//    dn_data = 0. up_ready = 0 while rst_n is low; it is 1 in the first cycle
//    after release. Reset mid-stream drops all in-flight beats.
//  - Handshake: a beat transfers when valid & ready on the same posedge.
//    dn_valid is held, and dn_data/dn_sat stay stable, until dn_ready.
//    up_ready = ~s1_valid | ~s2_valid | dn_ready (combinational, no loss).
//  - S1 (accept): x = sign-extend(up_data) to NUM_WIDTH; p = x << shift.
//    ovf = 1 if any bit shifted out above NUM_WIDTH-1, or bit NUM_WIDTH-1 of
//    p, differs from the sign of up_data. Register p, ovf, sign.
//  - S2 (output): ovf & ~sign -> NUM_MAX = {0,1...1}; ovf & sign ->
//    NUM_MIN = {1,0...0}; otherwise p. dn_sat = ovf.
//  - Latency: 2 cycles accept->dn_valid when unstalled. Throughput: 1 beat/clk.
//  - Boundary rules:
//    - shift >= NUM_WIDTH: zero input -> 0 with dn_sat=0; any nonzero input
//      saturates. -1 at shift=NUM_WIDTH-1 gives exactly NUM_MIN, no sat.
//    - Result exactly NUM_MIN/NUM_MAX without overflow: dn_sat=0.
//    - Stall: S2 holds while dn_valid & ~dn_ready. S1 advances into S2 only
//      when S2 is empty or draining. Beat order is preserved.
//    - Simultaneous accept and drain in one cycle: both occur, and occupancy
//      stays constant.
// STRUCTURE
//  - Shared package stream_filter_pkg holds:
//    - IMG_MAX, IMG_MIN, NUM_MAX, NUM_MIN constant functions of width
//      (also used by rescale);
//    - a sat_shl overflow-detect function.
//  - Sub-module pipe_slice: a generic 1-entry valid/ready register slice,
//    parameterised by payload width. It is instantiated twice (S1 with payload
//    {p,ovf,sign}, S2 with payload {dn_data,dn_sat}); the shift and saturate
//    logic sits between the slices.
// TESTING  (NUM_WIDTH=33, IMG_WIDTH=16, dn_ready=1 unless stated)
//  1. up_data=16'h0005, shift=4 -> 2 clks later dn_data=33'h0_0000_0050,
//     dn_sat=0.
//  2. up_data=16'hFFFE, shift=3 -> dn_data=33'h1_FFFF_FFF0 (-16), dn_sat=0.
//  3. Positive saturation: 16'h7FFF, shift=17 -> 33'h0_FFFE_0000, sat=0;
//     shift=18 -> 33'h0_FFFF_FFFF, sat=1.
//  4. Negative boundary and saturation: 16'h8000, shift=17 -> 33'h1_0000_0000,
//     sat=0; shift=18 -> 33'h1_0000_0000, sat=1. shift=200: data 0 -> 0,
//     sat=0; data 1 -> NUM_MAX, sat=1.
//  5. Back-to-back 1,2,3,4 (shift=0) with dn_ready=0 for 6 clks:
//     - up_ready drops after 2 accepts;
//     - dn_data stays at 1 while stalled;
//     - after release, outputs are 1,2,3,4 in order, with no gaps and no
//       duplicates.
//  6. rst_n low for 1 clk while dn_valid=1: dn_valid and dn_data go to 0
//     immediately, with no output after release until new input. up_ready=1
//     first cycle after release.

Source files
------------

// File: rtl/stream_filter_pkg.sv
// stream_filter_pkg: width-generic signed range constants and shift-overflow detection
package stream_filter_pkg;
  function automatic logic [63:0] img_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] img_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
  function automatic logic [63:0] num_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] num_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
  // x is already sign-extended to 64 bits; overflow means the top sh+1 bits of the w-bit value are not all sign
  function automatic logic sat_shl(input logic [63:0] x, input logic [7:0] sh, input int w);
    int s;
    logic [63:0] t;
    s = int'(sh);
    if (s >= w) return x != 64'd0;
    t = 64'($signed(x) >>> (w - 1 - s));
    return t != {64{x[63]}};
  endfunction
endpackage

// File: rtl/pipe_slice.sv
// pipe_slice: one-entry valid/ready register slice with generic payload width
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_ready,
  output logic [W-1:0] dn_data,
  output logic         dn_valid,
  input  logic         dn_ready
);
  assign up_ready = ~dn_valid | dn_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
endmodule

// File: rtl/upscale.sv
// upscale: widen signed pixels to the number domain with left shift and saturation
module upscale
  import stream_filter_pkg::*;
#(
  parameter int NUM_WIDTH = 33,
  parameter int IMG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           shift,
  input  logic [IMG_WIDTH-1:0] up_data,
  input  logic                 up_valid,
  output logic                 up_ready,
  output logic [NUM_WIDTH-1:0] dn_data,
  output logic                 dn_sat,
  output logic                 dn_valid,
  input  logic                 dn_ready
);
  localparam logic [NUM_WIDTH-1:0] NMAX = NUM_WIDTH'(num_max(NUM_WIDTH));
  localparam logic [NUM_WIDTH-1:0] NMIN = NUM_WIDTH'(num_min(NUM_WIDTH));
  logic [NUM_WIDTH-1:0] p, s1_p, s2_data;
  logic ovf, s1_ovf, s1_sign, s1_valid, s1_ready, s2_ready;
  assign p   = NUM_WIDTH'($signed(up_data)) << shift;
  assign ovf = sat_shl(64'($signed(up_data)), shift, NUM_WIDTH);
  pipe_slice #(.W(NUM_WIDTH + 2)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .up_data({p, ovf, up_data[IMG_WIDTH-1]}), .up_valid(up_valid), .up_ready(s1_ready),
    .dn_data({s1_p, s1_ovf, s1_sign}), .dn_valid(s1_valid), .dn_ready(s2_ready)
  );
  assign s2_data = s1_ovf ? (s1_sign ? NMIN : NMAX) : s1_p;
  pipe_slice #(.W(NUM_WIDTH + 1)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .up_data({s2_data, s1_ovf}), .up_valid(s1_valid), .up_ready(s2_ready),
    .dn_data({dn_data, dn_sat}), .dn_valid(dn_valid), .dn_ready(dn_ready)
  );
  assign up_ready = rst_n & s1_ready;
endmodule

// File: tb/tb_upscale.sv
// tb_upscale: directed and randomized checks of upscale against an arithmetic model
module tb_upscale;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  shift = 8'd0;
  logic [15:0] up_data = 16'd0;
  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [32:0] dn_data;
  logic        dn_sat;
  logic        dn_valid;
  logic        dn_ready = 1'b1;
  int compared = 0;
  int mismatched = 0;
  localparam logic [32:0] NMAX = 33'h0_FFFF_FFFF;
  localparam logic [32:0] NMIN = 33'h1_0000_0000;

  upscale #(.NUM_WIDTH(33), .IMG_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .shift(shift), .up_data(up_data), .up_valid(up_valid),
    .up_ready(up_ready), .dn_data(dn_data), .dn_sat(dn_sat), .dn_valid(dn_valid),
    .dn_ready(dn_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, compared=%0d", compared);
    $fatal(1);
  end

  function automatic void model(input logic [15:0] d, input logic [7:0] sh,
                                output logic [32:0] e, output logic es);
    longint v;
    longint hi = (longint'(1) << 32) - 1;
    longint lo = -(longint'(1) << 32);
    e = 33'd0;
    es = 1'b0;
    if (d == 16'd0) return;
    if (sh >= 8'd33) begin
      es = 1'b1;
      e = d[15] ? NMIN : NMAX;
      return;
    end
    v = longint'($signed(d)) * (longint'(1) << sh);
    if (v > hi) begin es = 1'b1; e = NMAX; end
    else if (v < lo) begin es = 1'b1; e = NMIN; end
    else e = 33'(v);
  endfunction

  task automatic run_beat(input logic [15:0] d, input logic [7:0] sh,
                          output logic [32:0] od, output logic os, output int lat);
    @(negedge clk);
    up_data = d; shift = sh; up_valid = 1'b1; dn_ready = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    lat = 1;
    while (!dn_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    od = dn_data;
    os = dn_sat;
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if (dn_valid !== 1'b0 || dn_data !== 33'd0 || dn_sat !== 1'b0 || up_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got valid=%b data=%h sat=%b ready=%b want 0 0 0 0",
               dn_valid, dn_data, dn_sat, up_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (up_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b want 1", up_ready);
    end
  endtask

  task automatic test_basic();
    logic [32:0] od;
    logic os;
    int lat;
    run_beat(16'h0005, 8'd4, od, os, lat);
    compared++;
    if (lat !== 2) begin mismatched++; $display("FAIL basic_latency: got %0d want 2", lat); end
    compared++;
    if (od !== 33'h0_0000_0050 || os !== 1'b0) begin
      mismatched++; $display("FAIL basic_pos: got %h sat=%b want 000000050 sat=0", od, os);
    end
    run_beat(16'hFFFE, 8'd3, od, os, lat);
    compared++;
    if (od !== 33'h1_FFFF_FFF0 || os !== 1'b0) begin
      mismatched++; $display("FAIL basic_neg: got %h sat=%b want 1fffffff0 sat=0", od, os);
    end
  endtask

  task automatic test_boundary();
    logic [15:0] td [10] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000,
                             16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001};
    logic [7:0]  ts [10] = '{8'd17, 8'd18, 8'd17, 8'd18, 8'd200, 8'd200, 8'd32, 8'd33, 8'd31, 8'd32};
    logic [32:0] te [10] = '{33'h0_FFFE_0000, NMAX, NMIN, NMIN, 33'd0, NMAX, NMIN, NMIN,
                             33'h0_8000_0000, NMAX};
    logic        tsat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [32:0] od;
    logic os;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_beat(td[i], ts[i], od, os, lat);
      compared++;
      if (od !== te[i]) begin
        mismatched++;
        $display("FAIL boundary_data[%0d] d=%h sh=%0d: got %h want %h", i, td[i], ts[i], od, te[i]);
      end
      compared++;
      if (os !== tsat[i]) begin
        mismatched++;
        $display("FAIL boundary_sat[%0d] d=%h sh=%0d: got %b want %b", i, td[i], ts[i], os, tsat[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [32:0] qd[$];
    logic qs[$];
    logic [32:0] e;
    logic es;
    logic hold = 1'b0;
    logic [32:0] hd = 33'd0;
    logic hs = 1'b0;
    int r;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 3));
      up_valid = c < 360 && $urandom_range(0, 3) != 0;
      up_data = r == 0 ? 16'($urandom_range(0, 2)) - 16'd1 : 16'($urandom);
      shift = $urandom_range(0, 7) == 0 ? 8'($urandom) : 8'($urandom_range(0, 34));
      dn_ready = c >= 360 || $urandom_range(0, 2) != 0;
      #1;
      if (hold) begin
        compared++;
        if (dn_valid !== 1'b1 || dn_data !== hd || dn_sat !== hs) begin
          mismatched++;
          $display("FAIL stall_hold: got v=%b %h sat=%b want v=1 %h sat=%b", dn_valid, dn_data, dn_sat, hd, hs);
        end
      end
      if (dn_valid && dn_ready) begin
        compared++;
        if (qd.size() == 0) begin
          mismatched++;
          $display("FAIL rand_spurious: got beat %h with nothing expected", dn_data);
        end else begin
          e = qd.pop_front();
          es = qs.pop_front();
          if (dn_data !== e || dn_sat !== es) begin
            mismatched++;
            $display("FAIL rand_beat: got %h sat=%b want %h sat=%b", dn_data, dn_sat, e, es);
          end
        end
      end
      hold = dn_valid && !dn_ready;
      hd = dn_data;
      hs = dn_sat;
      if (up_valid && up_ready) begin
        model(up_data, shift, e, es);
        qd.push_back(e);
        qs.push_back(es);
      end
    end
    up_valid = 1'b0;
    compared++;
    if (qd.size() != 0) begin
      mismatched++;
      $display("FAIL rand_leftover: got %0d beats undelivered want 0", qd.size());
    end
  endtask

  task automatic test_back_to_back();
    int nxt = 1;
    int got = 0;
    int acc = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      up_valid = nxt <= 4;
      up_data = 16'(nxt);
      shift = 8'd0;
      dn_ready = c >= 6;
      #1;
      if (c == 2) begin
        compared++;
        if (up_ready !== 1'b0 || acc != 2) begin
          mismatched++;
          $display("FAIL b2b_ready_drop: got ready=%b accepts=%0d want ready=0 accepts=2", up_ready, acc);
        end
      end
      if (dn_valid && !dn_ready) begin
        compared++;
        if (dn_data !== 33'd1) begin
          mismatched++; $display("FAIL b2b_stall_data: got %h want 1", dn_data);
        end
      end
      if (dn_ready) begin
        compared++;
        if (!dn_valid) begin
          mismatched++; $display("FAIL b2b_gap: got dn_valid=0 want 1 (beat %0d)", got + 1);
        end else begin
          if (dn_data !== 33'(got + 1)) begin
            mismatched++; $display("FAIL b2b_order: got %h want %h", dn_data, 33'(got + 1));
          end
          got++;
        end
      end
      if (up_valid && up_ready) begin
        nxt++;
        acc++;
      end
    end
    up_valid = 1'b0;
    compared++;
    if (got != 4) begin
      mismatched++; $display("FAIL b2b_count: got %0d want 4", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] od;
    logic os;
    int lat;
    int w = 0;
    int stray = 0;
    @(negedge clk);
    up_data = 16'h0003; shift = 8'd0; up_valid = 1'b1; dn_ready = 1'b0;
    @(negedge clk);
    up_valid = 1'b0;
    while (!dn_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    compared++;
    if (dn_valid !== 1'b1) begin
      mismatched++; $display("FAIL rstmid_setup: got dn_valid=%b want 1", dn_valid);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (dn_valid !== 1'b0 || dn_data !== 33'd0 || dn_sat !== 1'b0 || up_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_clear: got valid=%b data=%h sat=%b ready=%b want 0 0 0 0",
               dn_valid, dn_data, dn_sat, up_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn_ready = 1'b1;
    #1;
    compared++;
    if (up_ready !== 1'b1) begin
      mismatched++; $display("FAIL rstmid_ready: got %b want 1", up_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dn_valid) stray++;
    end
    compared++;
    if (stray != 0) begin
      mismatched++; $display("FAIL rstmid_stray: got %0d output beats want 0", stray);
    end
    run_beat(16'h0007, 8'd1, od, os, lat);
    compared++;
    if (od !== 33'd14 || os !== 1'b0 || lat != 2) begin
      mismatched++;
      $display("FAIL rstmid_after: got %h sat=%b lat=%0d want 00000000e sat=0 lat=2", od, os, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
